// File: rtl/sync_memory_block.sv
// sync_memory_block: clocked byte/half/word data memory with a hardware
// clear sequence after reset, registered loads with a valid strobe and a
// one-cycle error strobe for rejected requests.
module sync_memory_block #(
    parameter int ADDR_WIDTH  = 18,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            access_size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  read_valid,
    output logic                  busy,
    output logic                  error
);

    localparam int CNT_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int IDX_W = ADDR_WIDTH - 2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH_WORDS - 1);
    localparam logic [IDX_W:0]   DEPTH_LIM = (IDX_W + 1)'(DEPTH_WORDS);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_mem [0:DEPTH_WORDS-1];
    logic [31:0]      r_read_data;
    logic             r_read_valid;
    logic             r_error;

    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lane;
    logic             w_clearing;
    logic             w_ready;
    logic             w_req;
    logic             w_align_bad;
    logic             w_range_bad;
    logic             w_bad;
    logic             w_ld_ok;
    logic             w_st_ok;
    logic [CNT_W-1:0] w_mem_idx;
    logic [3:0]       w_we;
    logic [31:0]      w_wdata;
    logic [31:0]      w_rword;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_val;

    assign w_idx      = address[ADDR_WIDTH-1:2];
    assign w_lane     = address[1:0];
    assign w_clearing = (r_state == ST_CLEAR);
    assign w_ready    = (r_state == ST_READY);
    assign w_req      = mem_read | mem_write;

    // Request validation: alignment, reserved size, range and read/write conflict
    always_comb begin
        case (access_size)
            2'b00:   w_align_bad = 1'b0;
            2'b01:   w_align_bad = address[0];
            2'b10:   w_align_bad = |address[1:0];
            default: w_align_bad = 1'b1;
        endcase
        w_range_bad = ({1'b0, w_idx} >= DEPTH_LIM);
        w_bad       = (mem_read & mem_write) | w_align_bad | w_range_bad;
        w_ld_ok     = w_ready & mem_read  & ~w_bad;
        w_st_ok     = w_ready & mem_write & ~w_bad;
    end

    // Write port: clear sequence owns the port while busy, otherwise lane-enabled stores
    always_comb begin
        w_mem_idx = w_clearing ? r_cnt : w_idx[CNT_W-1:0];
        w_we      = '0;
        w_wdata   = '0;
        if (!reset) begin
            if (w_clearing) begin
                w_we = '1;
            end else if (w_st_ok) begin
                case (access_size)
                    2'b00: begin
                        w_we    = 4'b0001 << w_lane;
                        w_wdata = {4{write_data[7:0]}};
                    end
                    2'b01: begin
                        w_we    = address[1] ? 4'b1100 : 4'b0011;
                        w_wdata = {2{write_data[15:0]}};
                    end
                    default: begin
                        w_we    = '1;
                        w_wdata = write_data;
                    end
                endcase
            end
        end
    end

    // Load path: lane select, right-justify and extend
    always_comb begin
        w_rword = r_mem[w_mem_idx];
        w_byte  = w_rword[{w_lane, 3'b000} +: 8];
        w_half  = address[1] ? w_rword[31:16] : w_rword[15:0];
        case (access_size)
            2'b00:   w_load_val = {{24{sign_ext & w_byte[7]}}, w_byte};
            2'b01:   w_load_val = {{16{sign_ext & w_half[15]}}, w_half};
            default: w_load_val = w_rword;
        endcase
    end

    // Storage array, byte-lane writes
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (w_we[b]) begin
                r_mem[w_mem_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
        end
    end

    // Control: clear sequencing, registered load result and strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_cnt        <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_read_valid <= 1'b0;
            r_error      <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    if (r_cnt == LAST_IDX) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_error <= w_req & w_bad;
                    if (w_ld_ok) begin
                        r_read_data  <= w_load_val;
                        r_read_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
    assign error      = r_error;
    assign busy       = w_clearing;

endmodule

// File: doc/sync_memory_block.md
Name: sync_memory_block

Overview:
Clocked, parametrised data memory: the successor to the asynchronous byte/word data memory. Sits on the datapath load/store port. Supports byte, halfword and word accesses, zero or sign extension on loads, and a registered read with a valid strobe. After reset it runs a hardware clear sequence and raises an error pulse on misaligned, out-of-range or conflicting requests.

Parameters:
ADDR_WIDTH, 18, byte-address width.
DEPTH_WORDS, 256, number of 32-bit words stored. Valid range is 1 to 2^(ADDR_WIDTH-2). A power of two is not required.

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
mem_read  in  1  load request, sampled each cycle.
mem_write  in  1  store request, sampled each cycle.
access_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends.
address  in  ADDR_WIDTH  byte address, little-endian.
write_data  in  32  store data; byte/half taken from low bits.
read_data  out  32  registered load result.
read_valid  out  1  one-cycle strobe, read_data updated.
busy  out  1  clear sequence in progress; requests ignored.
error  out  1  one-cycle strobe, request rejected.

Behaviour:
- Reset state: state=CLEAR, clear counter=0, read_data=0, read_valid=0, error=0, busy=1.
- CLEAR state:
  - Each cycle, write 0 to word[counter] and increment counter.
  - After word DEPTH_WORDS-1 is written, go to READY. busy falls on that edge, so busy is high for exactly DEPTH_WORDS cycles after reset deasserts.
  - mem_read and mem_write are ignored: no access, error stays 0, read_valid stays 0.
- Reset asserted in any state, including mid-clear or mid-request, restarts CLEAR from counter 0. Any pending read_valid is dropped.
- READY state:
  - Word index = address[ADDR_WIDTH-1:2]; lane = address[1:0].
  - Rejected requests: error=1 for the next cycle, memory unchanged, read_valid=0. A request is rejected if any of these holds:
    - mem_read and mem_write both high;
    - access_size=11;
    - half with address[0]=1;
    - word with address[1:0]!=00;
    - index >= DEPTH_WORDS.
  - Store:
    - Committed on the request edge.
    - Byte: writes write_data[7:0] into lane byte.
    - Half: writes write_data[15:0] into bytes lane and lane+1.
    - Word: writes all 32 bits.
    - Bytes outside the selected lanes are preserved.
  - Load:
    - read_data and read_valid=1 appear on the edge after the request (latency 1).
    - Byte/half loads are right-justified, then zero- or sign-extended per sign_ext. Sign is taken from bit 7 (byte) or bit 15 (half). Word ignores sign_ext.
    - read_valid is high exactly one cycle per accepted load. Back-to-back loads give back-to-back strobes.
  - read_data holds its last value until the next accepted load. It is not cleared by rejected requests.
  - A load in the cycle after a store to the same word returns the stored data; no bypass is needed since the store commits first.
- Storage is single-port; there is no simultaneous read and write.
- Neither mem_read nor mem_write high: no operation, strobes low.

Test Plan:
- Clear: assert reset 2 cycles, release -> busy high exactly 256 cycles then 0. Word load at 0x00008 -> next cycle read_valid=1, read_data=0x00000000. A store issued while busy leaves word 0 = 0.
- Word store/load: store 0xFFFFFFFF at 0x00008 (size 10), then load the same address -> next cycle read_data=0xFFFFFFFF, read_valid=1 for one cycle, error=0.
- Byte lanes and extension:
  - Word store 0x00000000 at 0x00010, then byte store 0x80 at 0x00011.
  - Word load -> 0x00008000.
  - Byte load 0x00011 with sign_ext=1 -> 0xFFFFFF80; with sign_ext=0 -> 0x00000080.
  - Half store 0xBEEF at 0x00012, then word load -> 0xBEEF8000.
- Rejection:
  - Each rejected case -> error=1 for one cycle, read_valid=0, and a follow-up word load returns the unchanged data:
    - half load at 0x00013;
    - word store at 0x00002;
    - access_size=11;
    - address 0x00400 (index 256);
    - mem_read=mem_write=1.
  - read_data retains 0xBEEF8000 throughout.
- Reset mid-operation: pulse reset during cycle 100 of the clear sequence -> busy stays high for 256 more cycles. Assert reset on the same edge as a load -> no read_valid, read_data=0.
